// File: rtl/channel_writer.sv
// rtl/channel_writer.sv - packet to 4 KB slot writer over an AXI4 AW/W master
//
// Purpose:
//   Takes one metadata record plus a 512-bit data stream per packet. Each
//   packet is written to a 4 KB slot derived from qpn/msg_num/pkg_num. The
//   slot is written as up to eight 16-beat INCR bursts of 256-bit beats.
//   Every 512-bit input beat is split into two W beats: low half first.
//   A packet that ends mid-burst is padded with zero-strobe beats up to the
//   burst end. Only one burst is outstanding, and B responses are not used.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   io_aw_*                 AXI write address channel (len/size/burst fixed)
//   io_w_*                  AXI write data channel (256-bit data, 32-bit strb)
//   io_recv_meta_*          packet metadata (qpn, msg_num, pkg_num, pkg_total)
//   io_recv_data_*          packet data stream (512-bit data, 64-bit keep, last)

module channel_writer #(
  parameter logic [32:0] BASE_ADDR = 33'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_aw_ready,
  output logic         io_aw_valid,
  output logic [32:0]  io_aw_bits_addr,
  output logic [1:0]   io_aw_bits_burst,
  output logic [3:0]   io_aw_bits_cache,
  output logic [5:0]   io_aw_bits_id,
  output logic [3:0]   io_aw_bits_len,
  output logic         io_aw_bits_lock,
  output logic [2:0]   io_aw_bits_prot,
  output logic [3:0]   io_aw_bits_qos,
  output logic [3:0]   io_aw_bits_region,
  output logic [2:0]   io_aw_bits_size,
  input  logic         io_w_ready,
  output logic         io_w_valid,
  output logic [255:0] io_w_bits_data,
  output logic         io_w_bits_last,
  output logic [31:0]  io_w_bits_strb,
  output logic         io_recv_meta_ready,
  input  logic         io_recv_meta_valid,
  input  logic [15:0]  io_recv_meta_bits_qpn,
  input  logic [23:0]  io_recv_meta_bits_msg_num,
  input  logic [20:0]  io_recv_meta_bits_pkg_num,
  input  logic [20:0]  io_recv_meta_bits_pkg_total,
  output logic         io_recv_data_ready,
  input  logic         io_recv_data_valid,
  input  logic         io_recv_data_bits_last,
  input  logic [511:0] io_recv_data_bits_data,
  input  logic [63:0]  io_recv_data_bits_keep
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;

  logic [1:0]  state;
  logic [32:0] burst_addr;
  logic [3:0]  wbeat;     // W beat index within the current burst
  logic        half;      // 0: low 256 bits of the input beat, 1: high
  logic        pad;       // packet data exhausted, filling the burst with zeros
  logic        pkt_done;  // final input beat of the packet has been consumed
  logic [5:0]  in_cnt;    // input beats consumed so far in this packet

  logic [32:0] slot_addr;
  logic        w_fire;
  logic        consume;
  logic        ends_now;
  logic        ended;

  // Only the low bits of qpn/msg_num/pkg_num select the slot; pkg_total is
  // informational for this block.
  logic unused_bits;
  assign unused_bits = ^{io_recv_meta_bits_pkg_total,
                         io_recv_meta_bits_qpn[15:4],
                         io_recv_meta_bits_msg_num[23:8],
                         io_recv_meta_bits_pkg_num[20:9]};

  assign slot_addr = BASE_ADDR + {io_recv_meta_bits_qpn[3:0],
                                  io_recv_meta_bits_msg_num[7:0],
                                  io_recv_meta_bits_pkg_num[8:0],
                                  12'h000};

  // Fixed burst shape: 16 beats of 32 bytes, INCR.
  assign io_aw_bits_burst  = 2'b01;
  assign io_aw_bits_cache  = 4'h0;
  assign io_aw_bits_id     = 6'h0;
  assign io_aw_bits_len    = 4'hF;
  assign io_aw_bits_lock   = 1'b0;
  assign io_aw_bits_prot   = 3'h0;
  assign io_aw_bits_qos    = 4'h0;
  assign io_aw_bits_region = 4'h0;
  assign io_aw_bits_size   = 3'b101;
  assign io_aw_bits_addr   = burst_addr;

  // Handshake outputs are also gated by reset so that they drop the moment
  // reset asserts, not only after the state register clears.
  assign io_recv_meta_ready = reset && (state == S_IDLE);
  assign io_aw_valid        = reset && (state == S_AW);
  assign io_w_valid         = reset && (state == S_W) && (pad || io_recv_data_valid);

  // The input beat is released together with its upper half, so the W
  // channel sees a straight combinational pass-through of the input.
  assign io_recv_data_ready = reset && (state == S_W) && !pad && half && io_w_ready;

  always_comb begin
    io_w_bits_data = 256'h0;
    io_w_bits_strb = 32'h0;
    if (!pad) begin
      if (half) begin
        io_w_bits_data = io_recv_data_bits_data[511:256];
        io_w_bits_strb = io_recv_data_bits_keep[63:32];
      end else begin
        io_w_bits_data = io_recv_data_bits_data[255:0];
        io_w_bits_strb = io_recv_data_bits_keep[31:0];
      end
    end
  end

  assign io_w_bits_last = (wbeat == 4'hF);

  assign w_fire   = io_w_valid && io_w_ready;
  assign consume  = w_fire && !pad && half;
  // A missing last is truncated at the 64th input beat (the slot size).
  assign ends_now = consume && (io_recv_data_bits_last || (in_cnt == 6'd63));
  assign ended    = pkt_done || ends_now;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      burst_addr <= 33'h0;
      wbeat      <= 4'h0;
      half       <= 1'b0;
      pad        <= 1'b0;
      pkt_done   <= 1'b0;
      in_cnt     <= 6'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_recv_meta_valid) begin
            burst_addr <= slot_addr;
            wbeat      <= 4'h0;
            half       <= 1'b0;
            pad        <= 1'b0;
            pkt_done   <= 1'b0;
            in_cnt     <= 6'h0;
            state      <= S_AW;
          end
        end
        S_AW: begin
          if (io_aw_ready) begin
            wbeat <= 4'h0;
            half  <= 1'b0;
            state <= S_W;
          end
        end
        S_W: begin
          if (w_fire) begin
            half  <= ~half;
            wbeat <= wbeat + 4'h1;
            if (consume) begin
              in_cnt <= in_cnt + 6'h1;
            end
            if (ends_now) begin
              pkt_done <= 1'b1;
            end
            if (wbeat == 4'hF) begin
              pad <= 1'b0;
              if (ended) begin
                state <= S_IDLE;
              end else begin
                burst_addr <= burst_addr + 33'd512;
                state      <= S_AW;
              end
            end else if (ends_now) begin
              // Data ran out mid-burst: finish the burst with empty beats.
              pad <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_writer.sv
// tb/tb_channel_writer.sv - self-checking bench for channel_writer
module tb_channel_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_aw_ready = 1'b1;
  logic         io_aw_valid;
  logic [32:0]  io_aw_bits_addr;
  logic [1:0]   io_aw_bits_burst;
  logic [3:0]   io_aw_bits_cache;
  logic [5:0]   io_aw_bits_id;
  logic [3:0]   io_aw_bits_len;
  logic         io_aw_bits_lock;
  logic [2:0]   io_aw_bits_prot;
  logic [3:0]   io_aw_bits_qos;
  logic [3:0]   io_aw_bits_region;
  logic [2:0]   io_aw_bits_size;
  logic         io_w_ready = 1'b1;
  logic         io_w_valid;
  logic [255:0] io_w_bits_data;
  logic         io_w_bits_last;
  logic [31:0]  io_w_bits_strb;
  logic         io_recv_meta_ready;
  logic         io_recv_meta_valid = 1'b0;
  logic [15:0]  io_recv_meta_bits_qpn = '0;
  logic [23:0]  io_recv_meta_bits_msg_num = '0;
  logic [20:0]  io_recv_meta_bits_pkg_num = '0;
  logic [20:0]  io_recv_meta_bits_pkg_total = '0;
  logic         io_recv_data_ready;
  logic         io_recv_data_valid = 1'b0;
  logic         io_recv_data_bits_last = 1'b0;
  logic [511:0] io_recv_data_bits_data = '0;
  logic [63:0]  io_recv_data_bits_keep = '0;

  channel_writer dut (
    .clock(clock), .reset(reset),
    .io_aw_ready(io_aw_ready), .io_aw_valid(io_aw_valid),
    .io_aw_bits_addr(io_aw_bits_addr), .io_aw_bits_burst(io_aw_bits_burst),
    .io_aw_bits_cache(io_aw_bits_cache), .io_aw_bits_id(io_aw_bits_id),
    .io_aw_bits_len(io_aw_bits_len), .io_aw_bits_lock(io_aw_bits_lock),
    .io_aw_bits_prot(io_aw_bits_prot), .io_aw_bits_qos(io_aw_bits_qos),
    .io_aw_bits_region(io_aw_bits_region), .io_aw_bits_size(io_aw_bits_size),
    .io_w_ready(io_w_ready), .io_w_valid(io_w_valid),
    .io_w_bits_data(io_w_bits_data), .io_w_bits_last(io_w_bits_last),
    .io_w_bits_strb(io_w_bits_strb),
    .io_recv_meta_ready(io_recv_meta_ready), .io_recv_meta_valid(io_recv_meta_valid),
    .io_recv_meta_bits_qpn(io_recv_meta_bits_qpn),
    .io_recv_meta_bits_msg_num(io_recv_meta_bits_msg_num),
    .io_recv_meta_bits_pkg_num(io_recv_meta_bits_pkg_num),
    .io_recv_meta_bits_pkg_total(io_recv_meta_bits_pkg_total),
    .io_recv_data_ready(io_recv_data_ready), .io_recv_data_valid(io_recv_data_valid),
    .io_recv_data_bits_last(io_recv_data_bits_last),
    .io_recv_data_bits_data(io_recv_data_bits_data),
    .io_recv_data_bits_keep(io_recv_data_bits_keep)
  );

  always #5 clock = ~clock;

  typedef struct {logic [511:0] data; logic [63:0] keep; logic last;} beat_t;
  typedef struct {logic [15:0] qpn; logic [23:0] msg; logic [20:0] pkg;} meta_t;
  typedef struct {logic [255:0] data; logic [31:0] strb; logic last;} wb_t;
  typedef struct {
    logic [15:0] qpn; logic [23:0] msg; logic [20:0] pkg;
    int n; bit drop_last; bit ones;
    logic [32:0] exp_first; int exp_bursts;
  } vec_t;

  beat_t       din_q[$];
  meta_t       meta_q[$];
  logic [32:0] got_aw[$];
  logic [32:0] exp_aw[$];
  wb_t         got_w[$];
  wb_t         exp_w[$];
  int          meta_hs_w[$];

  int vectors = 0;
  int miscompares = 0;
  bit stall = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot base plus 512 B per burst; W stream is the
  // input halves in order, zero-padded to a whole number of 16-beat bursts.
  function automatic logic [32:0] slot_addr(meta_t m, int k);
    longint unsigned a;
    a = longint'(m.qpn % 16) * 64'h20000000 + longint'(m.msg % 256) * 64'h200000
      + longint'(m.pkg % 512) * 64'h1000 + longint'(k) * 512;
    return a[32:0];
  endfunction

  task automatic gen_packet(input meta_t m, input int n, input bit drop_last, input bit ones);
    beat_t b;
    wb_t   w;
    wb_t   pk[$];
    meta_q.push_back(m);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 16; j++) b.data[j*32 +: 32] = $urandom;
      b.keep = ones ? {64{1'b1}} : {$urandom, $urandom};
      b.last = (i == n - 1) && !drop_last;
      din_q.push_back(b);
      w.data = b.data[255:0];   w.strb = b.keep[31:0];  w.last = 0; pk.push_back(w);
      w.data = b.data[511:256]; w.strb = b.keep[63:32]; pk.push_back(w);
    end
    while (pk.size() % 16 != 0) begin
      w.data = '0; w.strb = '0; w.last = 0; pk.push_back(w);
    end
    for (int i = 0; i < pk.size(); i++) begin
      pk[i].last = (i % 16 == 15);
      exp_w.push_back(pk[i]);
    end
    for (int k = 0; k < pk.size() / 16; k++) exp_aw.push_back(slot_addr(m, k));
  endtask

  task automatic drain();
    int cyc = 0;
    while ((got_w.size() < exp_w.size() || got_aw.size() < exp_aw.size()) && cyc < 20000) begin
      @(posedge clock);
      cyc++;
    end
    repeat (6) @(posedge clock);
    vectors++;
    if (cyc >= 20000) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d W beats expected %0d", got_w.size(), exp_w.size());
    end
  endtask

  task automatic compare_sb();
    check("aw_count", 512'(got_aw.size()), 512'(exp_aw.size()));
    check("w_count", 512'(got_w.size()), 512'(exp_w.size()));
    for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++)
      check($sformatf("aw_addr[%0d]", i), 512'(got_aw[i]), 512'(exp_aw[i]));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      check($sformatf("w_data[%0d]", i), 512'(got_w[i].data), 512'(exp_w[i].data));
      check($sformatf("w_strb[%0d]", i), 512'(got_w[i].strb), 512'(exp_w[i].strb));
      check($sformatf("w_last[%0d]", i), 512'(got_w[i].last), 512'(exp_w[i].last));
    end
    got_aw.delete(); exp_aw.delete(); got_w.delete(); exp_w.delete();
  endtask

  // Input drivers: handshake sampled at negedge, inputs updated 1 ns after posedge.
  initial forever begin
    bit hs;
    @(negedge clock);
    hs = io_recv_data_valid && io_recv_data_ready;
    @(posedge clock); #1;
    if (hs && din_q.size() > 0) void'(din_q.pop_front());
    if (din_q.size() > 0 && !(stall && $urandom_range(0, 3) == 0)) begin
      io_recv_data_valid     = 1'b1;
      io_recv_data_bits_data = din_q[0].data;
      io_recv_data_bits_keep = din_q[0].keep;
      io_recv_data_bits_last = din_q[0].last;
    end else begin
      io_recv_data_valid = 1'b0;
    end
  end

  initial forever begin
    bit hs;
    @(negedge clock);
    hs = io_recv_meta_valid && io_recv_meta_ready;
    @(posedge clock); #1;
    if (hs && meta_q.size() > 0) void'(meta_q.pop_front());
    io_recv_meta_valid = meta_q.size() > 0;
    if (meta_q.size() > 0) begin
      io_recv_meta_bits_qpn     = meta_q[0].qpn;
      io_recv_meta_bits_msg_num = meta_q[0].msg;
      io_recv_meta_bits_pkg_num = meta_q[0].pkg;
      io_recv_meta_bits_pkg_total = 21'($urandom);
    end
  end

  initial forever begin
    @(posedge clock); #1;
    io_aw_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    io_w_ready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: records handshakes and checks hold-stability under backpressure.
  logic        aw_pend = 0;
  logic [32:0] aw_held;
  logic        w_pend = 0;
  wb_t         w_held;
  always @(negedge clock) begin
    wb_t w;
    if (reset) begin
      if (aw_pend && io_aw_valid) check("aw_hold", 512'(io_aw_bits_addr), 512'(aw_held));
      aw_pend = io_aw_valid && !io_aw_ready;
      aw_held = io_aw_bits_addr;
      w.data = io_w_bits_data; w.strb = io_w_bits_strb; w.last = io_w_bits_last;
      if (w_pend && io_w_valid)
        check("w_hold", 512'({w.data, w.strb, w.last}), 512'({w_held.data, w_held.strb, w_held.last}));
      w_pend = io_w_valid && !io_w_ready;
      w_held = w;
      if (io_aw_valid && io_aw_ready) begin
        got_aw.push_back(io_aw_bits_addr);
        check("aw_fields", 512'({io_aw_bits_burst, io_aw_bits_cache, io_aw_bits_id, io_aw_bits_len,
                                 io_aw_bits_lock, io_aw_bits_prot, io_aw_bits_qos, io_aw_bits_region,
                                 io_aw_bits_size}),
              512'({2'b01, 4'h0, 6'h0, 4'hF, 1'b0, 3'h0, 4'h0, 4'h0, 3'b101}));
      end
      if (io_w_valid && io_w_ready) got_w.push_back(w);
      if (io_recv_meta_valid && io_recv_meta_ready) meta_hs_w.push_back(got_w.size());
    end else begin
      aw_pend = 0;
      w_pend = 0;
    end
  end

  vec_t tv[6];

  initial begin
    meta_t m;
    tv[0] = '{16'h0,    24'h0,      21'h0,      64, 0, 0, 33'h0,         8};
    tv[1] = '{16'h1,    24'h2,      21'h3,      64, 0, 0, 33'h020403000, 8};
    tv[2] = '{16'hFFFF, 24'hFFFFFF, 21'h1FFFFF, 10, 0, 1, 33'h1FFFFF000, 2};
    tv[3] = '{16'h0012, 24'h000345, 21'h000101,  1, 0, 0, 33'h048B01000, 1};
    tv[4] = '{16'h3,    24'h0,      21'h1,      64, 1, 0, 33'h060001000, 8};
    tv[5] = '{16'h0,    24'h1,      21'h0,       8, 0, 0, 33'h000200000, 1};

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check("rst_aw_valid", 512'(io_aw_valid), 512'(0));
    check("rst_w_valid", 512'(io_w_valid), 512'(0));
    check("rst_meta_ready", 512'(io_recv_meta_ready), 512'(0));
    check("rst_data_ready", 512'(io_recv_data_ready), 512'(0));
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #2;
    check("idle_meta_ready", 512'(io_recv_meta_ready), 512'(1));

    // Directed table: addressing, truncation, short packet, padding
    for (int i = 0; i < 6; i++) begin
      m = '{tv[i].qpn, tv[i].msg, tv[i].pkg};
      gen_packet(m, tv[i].n, tv[i].drop_last, tv[i].ones);
      drain();
      check($sformatf("tv%0d_first_addr", i), 512'(got_aw.size() > 0 ? got_aw[0] : 33'h1_5555_5555), 512'(tv[i].exp_first));
      check($sformatf("tv%0d_bursts", i), 512'(got_aw.size()), 512'(tv[i].exp_bursts));
      check($sformatf("tv%0d_meta_ready", i), 512'(io_recv_meta_ready), 512'(1));
      compare_sb();
    end

    // Consecutive metas: second is held until the first packet's 128 beats finish
    meta_hs_w.delete();
    m = '{16'h0, 24'h0, 21'h0};
    gen_packet(m, 64, 0, 0);
    gen_packet(m, 64, 0, 0);
    drain();
    check("consec_meta_count", 512'(meta_hs_w.size()), 512'(2));
    if (meta_hs_w.size() == 2) begin
      check("consec_meta0_at", 512'(meta_hs_w[0]), 512'(0));
      check("consec_meta1_at", 512'(meta_hs_w[1]), 512'(128));
    end
    compare_sb();

    // Randomized packets under random backpressure and input gaps
    stall = 1;
    for (int p = 0; p < 6; p++) begin
      int n;
      bit dl;
      m = '{16'($urandom), 24'($urandom), 21'($urandom)};
      n = $urandom_range(1, 64);
      dl = (n == 64) && ($urandom_range(0, 1) == 1);
      gen_packet(m, n, dl, 0);
    end
    drain();
    compare_sb();

    // Reset mid-burst aborts the packet; a new packet then writes from its base
    m = '{16'h0, 24'h0, 21'h5};
    gen_packet(m, 64, 0, 0);
    begin
      int cyc = 0;
      while (got_w.size() < 20 && cyc < 5000) begin @(posedge clock); cyc++; end
    end
    @(posedge clock); #3 reset = 1'b0;
    #1;
    check("mid_rst_aw_valid", 512'(io_aw_valid), 512'(0));
    check("mid_rst_w_valid", 512'(io_w_valid), 512'(0));
    check("mid_rst_meta_ready", 512'(io_recv_meta_ready), 512'(0));
    check("mid_rst_data_ready", 512'(io_recv_data_ready), 512'(0));
    din_q.delete(); meta_q.delete();
    got_aw.delete(); exp_aw.delete(); got_w.delete(); exp_w.delete();
    stall = 0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    m = '{16'h2, 24'h1, 21'h4};
    gen_packet(m, 12, 0, 0);
    drain();
    check("post_rst_first_addr", 512'(got_aw.size() > 0 ? got_aw[0] : 33'h1_5555_5555), 512'(33'h040204000));
    compare_sb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
